// File: rtl/cache_associativa_lru.sv
`default_nettype none
// ============================================================================
// Module   : cache_associativa_lru
// Brief    : Fully-associative write-back cache, one word per line, true-LRU
//            replacement, valid/ready front end and req/ack memory back end.
// Revision : 1.0 - initial release
// ============================================================================
module cache_associativa_lru #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 5,
    parameter int WAYS   = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int AGE_W = $clog2(WAYS);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LOOKUP    = 3'd1;
    localparam logic [2:0] c_WRITEBACK = 3'd2;
    localparam logic [2:0] c_REFILL    = 3'd3;
    localparam logic [2:0] c_RESP      = 3'd4;

    logic [2:0]        r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [AGE_W-1:0]  r_victim;

    logic [WAYS-1:0]   r_valid;
    logic [WAYS-1:0]   r_dirty;
    logic [ADDR_W-1:0] r_tag  [WAYS];
    logic [DATA_W-1:0] r_data [WAYS];
    logic [AGE_W-1:0]  r_age  [WAYS];

    logic              r_rsp_hit;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [WAYS-1:0]   w_hit_vec;
    logic              w_hit;
    logic [AGE_W-1:0]  w_hit_idx;
    logic              w_any_free;
    logic [AGE_W-1:0]  w_free_idx;
    logic [AGE_W-1:0]  w_oldest;
    logic [AGE_W-1:0]  w_victim;
    logic              w_victim_dirty;
    logic              w_in_lookup;
    logic              w_mem_done;
    logic              w_wr_hit;
    logic              w_alloc;
    logic              w_fill;
    logic              w_wb_done;
    logic              w_touch;
    logic [AGE_W-1:0]  w_tgt_idx;
    logic [AGE_W-1:0]  w_tgt_age;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_match
            assign w_hit_vec[g] = r_valid[g] && (r_tag[g] == r_addr);
        end
    endgenerate

    // Descending scan so the lowest-index match / free line wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_oldest   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = AGE_W'(i);
            end
            if (!r_valid[i]) begin
                w_any_free = 1'b1;
                w_free_idx = AGE_W'(i);
            end
            if (r_age[i] == AGE_W'(WAYS - 1)) begin
                w_oldest = AGE_W'(i);
            end
        end
    end

    assign w_victim       = w_any_free ? w_free_idx : w_oldest;
    assign w_victim_dirty = r_valid[w_victim] && r_dirty[w_victim];
    assign w_in_lookup    = (r_state == c_LOOKUP);
    assign w_mem_done     = r_mem_req && mem_ack;
    assign w_wr_hit       = w_in_lookup && w_hit && r_write;
    assign w_alloc        = (w_in_lookup && !w_hit && r_write && !w_victim_dirty)
                          || ((r_state == c_WRITEBACK) && w_mem_done && r_write);
    assign w_fill         = (r_state == c_REFILL) && w_mem_done;
    assign w_wb_done      = (r_state == c_WRITEBACK) && w_mem_done;
    // Outside LOOKUP the victim has already been latched.
    assign w_tgt_idx      = w_in_lookup ? (w_hit ? w_hit_idx : w_victim) : r_victim;
    assign w_touch        = (w_in_lookup && (w_hit || (r_write && !w_victim_dirty)))
                          || w_fill || (w_wb_done && r_write);
    assign w_tgt_age      = r_age[w_tgt_idx];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < WAYS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
                r_age[i]  <= AGE_W'(i);
            end
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (w_tgt_idx == AGE_W'(i)) begin
                    if (w_wr_hit) begin
                        r_data[i]  <= r_wdata;
                        r_dirty[i] <= 1'b1;
                    end
                    if (w_alloc) begin
                        r_tag[i]   <= r_addr;
                        r_data[i]  <= r_wdata;
                        r_valid[i] <= 1'b1;
                        r_dirty[i] <= 1'b1;
                    end
                    if (w_fill) begin
                        r_tag[i]   <= r_addr;
                        r_data[i]  <= mem_rdata;
                        r_valid[i] <= 1'b1;
                        r_dirty[i] <= 1'b0;
                    end
                    if (w_wb_done && !r_write) begin
                        r_dirty[i] <= 1'b0;
                    end
                end
                if (w_touch) begin
                    if (w_tgt_idx == AGE_W'(i)) begin
                        r_age[i] <= '0;
                    end else if (r_age[i] < w_tgt_age) begin
                        r_age[i] <= r_age[i] + AGE_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_victim    <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= c_LOOKUP;
                    end
                end
                c_LOOKUP: begin
                    r_victim  <= w_victim;
                    r_rsp_hit <= w_hit;
                    if (w_hit) begin
                        if (!r_write) begin
                            r_rsp_rdata <= r_data[w_hit_idx];
                        end
                        r_state <= c_RESP;
                    end else if (w_victim_dirty) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_tag[w_victim];
                        r_mem_wdata <= r_data[w_victim];
                        r_state     <= c_WRITEBACK;
                    end else if (!r_write) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                        r_state    <= c_REFILL;
                    end else begin
                        r_state <= c_RESP;
                    end
                end
                c_WRITEBACK: begin
                    if (w_mem_done) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= r_write ? c_RESP : c_REFILL;
                    end
                end
                c_REFILL: begin
                    // After a write-back, mem_req is low for one cycle before the refill request.
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                    end else if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_rsp_rdata <= mem_rdata;
                        r_state     <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = (r_state == c_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_hit   = r_rsp_hit;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
